// File: rtl/data_mem_resp.sv
// Data-memory responder for the core's MEM stage.
// Holds a word-organised RAM plus a 16-byte MMIO window:
//   +0x0 MTIME_LO (RO), +0x4 MTIME_HI (RO), +0x8 TOHOST (RW), +0xC SCRATCH (RW).
// Reads have one cycle of latency. A read and a write to the same word at the
// same edge return the write data (write-first).
module data_mem_resp #(
   parameter int          ADDR_W    = 12,
   parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data_raddr,
   input  logic        data_re,
   output logic [31:0] data_rdata,
   output logic        data_rvalid,
   input  logic [31:0] data_waddr,
   input  logic        data_we,
   input  logic [31:0] data_wdata,
   output logic        tohost_valid,
   output logic [31:0] tohost_data,
   output logic        err_misalign,
   output logic        err_range
);

   localparam int DEPTH = 1 << ADDR_W;

   // Identifies which register feeds data_rdata for the latest read response
   typedef enum logic [1:0] {
      SRC_ZERO = 2'd0,
      SRC_RAM  = 2'd1,
      SRC_MMIO = 2'd2
   } rd_src_t;

   localparam logic [1:0] OFF_MTIME_LO = 2'd0;
   localparam logic [1:0] OFF_MTIME_HI = 2'd1;
   localparam logic [1:0] OFF_TOHOST   = 2'd2;
   localparam logic [1:0] OFF_SCRATCH  = 2'd3;

   logic [31:0]       mem [0:DEPTH-1];

   logic              rd_ram_hit;
   logic              rd_mmio_hit;
   logic [ADDR_W-1:0] rd_idx;
   logic [1:0]        rd_off;
   logic              wr_ram_hit;
   logic              wr_mmio_hit;
   logic [ADDR_W-1:0] wr_idx;
   logic [1:0]        wr_off;

   logic              wr_ram;
   logic              wr_tohost;
   logic              wr_scratch;

   logic [31:0]       ram_rd_reg;
   logic [31:0]       mmio_rd_reg;
   logic [31:0]       mmio_rd_next;
   rd_src_t           rd_src_reg;
   rd_src_t           rd_src_next;
   logic              rvalid_reg;

   logic [63:0]       mtime_reg;
   logic [31:0]       scratch_reg;
   logic [31:0]       tohost_data_reg;
   logic              tohost_valid_reg;
   logic              err_misalign_reg;
   logic              err_range_reg;

   // Address decode; read and write ports are decoded independently, and the
   // two low byte-offset bits never take part in selection
   always_comb begin
      rd_ram_hit  = (data_raddr[31:ADDR_W+2] == '0);
      rd_mmio_hit = (data_raddr[31:4] == MMIO_BASE[31:4]);
      rd_idx      = data_raddr[ADDR_W+1:2];
      rd_off      = data_raddr[3:2];
      wr_ram_hit  = (data_waddr[31:ADDR_W+2] == '0);
      wr_mmio_hit = (data_waddr[31:4] == MMIO_BASE[31:4]);
      wr_idx      = data_waddr[ADDR_W+1:2];
      wr_off      = data_waddr[3:2];
      wr_ram      = data_we & wr_ram_hit;
      wr_tohost   = data_we & wr_mmio_hit & (wr_off == OFF_TOHOST);
      wr_scratch  = data_we & wr_mmio_hit & (wr_off == OFF_SCRATCH);
   end

   // RAM write port; contents are deliberately left unreset so it maps to block RAM
   always_ff @(posedge clk) begin
      if (wr_ram) begin
         mem[wr_idx] <= data_wdata;
      end
   end

   // RAM registered read, bypassing the same-edge write to the same word
   always_ff @(posedge clk) begin
      if (data_re && rd_ram_hit) begin
         if (wr_ram && (wr_idx == rd_idx)) begin
            ram_rd_reg <= data_wdata;
         end else begin
            ram_rd_reg <= mem[rd_idx];
         end
      end
   end

   // MMIO read mux; MTIME reads see the pre-increment value, RW registers are write-first
   always_comb begin
      mmio_rd_next = 32'd0;
      case (rd_off)
         OFF_MTIME_LO: mmio_rd_next = mtime_reg[31:0];
         OFF_MTIME_HI: mmio_rd_next = mtime_reg[63:32];
         OFF_TOHOST:   mmio_rd_next = wr_tohost  ? data_wdata : tohost_data_reg;
         OFF_SCRATCH:  mmio_rd_next = wr_scratch ? data_wdata : scratch_reg;
         default:      mmio_rd_next = 32'd0;
      endcase
   end

   // Response source for the read being accepted this edge; out-of-range reads return zero
   always_comb begin
      rd_src_next = SRC_ZERO;
      if (rd_ram_hit) begin
         rd_src_next = SRC_RAM;
      end else if (rd_mmio_hit) begin
         rd_src_next = SRC_MMIO;
      end
   end

   // Read response bookkeeping; everything holds while no read is issued
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_src_reg  <= SRC_ZERO;
         mmio_rd_reg <= 32'd0;
         rvalid_reg  <= 1'b0;
      end else begin
         rvalid_reg <= data_re;
         if (data_re) begin
            rd_src_reg <= rd_src_next;
            if (rd_mmio_hit) begin
               mmio_rd_reg <= mmio_rd_next;
            end
         end
      end
   end

   // Free-running cycle counter, wraps naturally at 2^64
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime_reg <= 64'd0;
      end else begin
         mtime_reg <= mtime_reg + 64'd1;
      end
   end

   // Writable MMIO registers; tohost_valid stays set until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scratch_reg      <= 32'd0;
         tohost_data_reg  <= 32'd0;
         tohost_valid_reg <= 1'b0;
      end else begin
         if (wr_scratch) begin
            scratch_reg <= data_wdata;
         end
         if (wr_tohost) begin
            tohost_data_reg  <= data_wdata;
            tohost_valid_reg <= 1'b1;
         end
      end
   end

   // Sticky error flags, set by either port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_misalign_reg <= 1'b0;
         err_range_reg    <= 1'b0;
      end else begin
         if ((data_re && (data_raddr[1:0] != 2'b00)) ||
             (data_we && (data_waddr[1:0] != 2'b00))) begin
            err_misalign_reg <= 1'b1;
         end
         if ((data_re && !rd_ram_hit && !rd_mmio_hit) ||
             (data_we && !wr_ram_hit && !wr_mmio_hit)) begin
            err_range_reg <= 1'b1;
         end
      end
   end

   // Output selection from registered sources only
   always_comb begin
      data_rdata = 32'd0;
      case (rd_src_reg)
         SRC_RAM:  data_rdata = ram_rd_reg;
         SRC_MMIO: data_rdata = mmio_rd_reg;
         default:  data_rdata = 32'd0;
      endcase
      data_rvalid  = rvalid_reg;
      tohost_valid = tohost_valid_reg;
      tohost_data  = tohost_data_reg;
      err_misalign = err_misalign_reg;
      err_range    = err_range_reg;
   end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp. Inputs change on the falling edge, the DUT
// samples them on the next rising edge, and outputs are checked on the
// following falling edge.
module tb_data_mem_resp;

   localparam logic [31:0] MMIO      = 32'h1000_0000;
   localparam logic [31:0] A_MT_LO   = MMIO + 32'h0;
   localparam logic [31:0] A_MT_HI   = MMIO + 32'h4;
   localparam logic [31:0] A_TOHOST  = MMIO + 32'h8;
   localparam logic [31:0] A_SCRATCH = MMIO + 32'hC;

   logic        clk;
   logic        rst_n;
   logic [31:0] data_raddr;
   logic        data_re;
   logic [31:0] data_rdata;
   logic        data_rvalid;
   logic [31:0] data_waddr;
   logic        data_we;
   logic [31:0] data_wdata;
   logic        tohost_valid;
   logic [31:0] tohost_data;
   logic        err_misalign;
   logic        err_range;

   int total;
   int bad;

   data_mem_resp #(
      .ADDR_W    (12),
      .MMIO_BASE (MMIO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_raddr   (data_raddr),
      .data_re      (data_re),
      .data_rdata   (data_rdata),
      .data_rvalid  (data_rvalid),
      .data_waddr   (data_waddr),
      .data_we      (data_we),
      .data_wdata   (data_wdata),
      .tohost_valid (tohost_valid),
      .tohost_data  (tohost_data),
      .err_misalign (err_misalign),
      .err_range    (err_range)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Set up the request for the next rising edge
   task automatic drive(input logic re, input logic [31:0] ra,
                        input logic we, input logic [31:0] wa, input logic [31:0] wd);
      data_re    = re;
      data_raddr = ra;
      data_we    = we;
      data_waddr = wa;
      data_wdata = wd;
      if (re || we)
         $display("txn t=%0t re=%0b raddr=%h we=%0b waddr=%h wdata=%h", $time, re, ra, we, wa, wd);
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
   endtask

   // One rising edge, then land on the falling edge for checking
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle();
      step();
      step();
      check("rst_rdata",   data_rdata,   32'h0);
      check("rst_rvalid",  {31'd0, data_rvalid},  32'd1 & 32'd0);
      check("rst_tohostv", {31'd0, tohost_valid}, 32'd0);
      check("rst_tohostd", tohost_data,  32'h0);
      check("rst_errmis",  {31'd0, err_misalign}, 32'd0);
      check("rst_errrng",  {31'd0, err_range},    32'd0);

      // Release on a falling edge; the next rising edge is cycle 0 and reads MTIME=0 there
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) step();   // cycles 0..99
      drive(1'b1, A_MT_LO, 1'b0, 32'h0, 32'h0);
      step();                                 // cycle 100
      check("mtime_rvalid", {31'd0, data_rvalid}, 32'd1);
      check("mtime_100",    data_rdata, 32'd100);
      drive(1'b0, 32'h0, 1'b1, A_MT_LO, 32'hFFFF_FFFF);
      step();                                 // cycle 101, write ignored
      check("mtime_wr_norv", {31'd0, data_rvalid}, 32'd0);
      drive(1'b1, A_MT_LO, 1'b0, 32'h0, 32'h0);
      step();                                 // cycle 102
      check("mtime_102", data_rdata, 32'd102);
      drive(1'b1, A_MT_HI, 1'b0, 32'h0, 32'h0);
      step();                                 // cycle 103
      check("mtime_hi", data_rdata, 32'd0);
      check("mtime_err", {30'd0, err_misalign, err_range}, 32'd0);

      // RAM write then read
      drive(1'b0, 32'h0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      step();
      check("wr_norv", {31'd0, data_rvalid}, 32'd0);
      drive(1'b1, 32'h0000_0010, 1'b0, 32'h0, 32'h0);
      step();
      check("rd10_rvalid", {31'd0, data_rvalid}, 32'd1);
      check("rd10_data",   data_rdata, 32'hDEAD_BEEF);
      idle();
      step();
      check("idle_rvalid", {31'd0, data_rvalid}, 32'd0);
      check("idle_hold",   data_rdata, 32'hDEAD_BEEF);
      check("t1_err", {30'd0, err_misalign, err_range}, 32'd0);

      // Same-edge write and read of one word: write-first
      drive(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0020, 32'h1234_5678);
      step();
      check("wf_rvalid", {31'd0, data_rvalid}, 32'd1);
      check("wf_data",   data_rdata, 32'h1234_5678);
      // Back-to-back reads; word 0 is written in parallel for the range test later
      drive(1'b1, 32'h0000_0010, 1'b1, 32'h0000_0000, 32'h1111_1111);
      step();
      check("b2b0_rv", {31'd0, data_rvalid}, 32'd1);
      check("b2b0",    data_rdata, 32'hDEAD_BEEF);
      drive(1'b1, 32'h0000_0020, 1'b0, 32'h0, 32'h0);
      step();
      check("b2b1_rv", {31'd0, data_rvalid}, 32'd1);
      check("b2b1",    data_rdata, 32'h1234_5678);
      drive(1'b1, 32'h0000_0010, 1'b0, 32'h0, 32'h0);
      step();
      check("b2b2_rv", {31'd0, data_rvalid}, 32'd1);
      check("b2b2",    data_rdata, 32'hDEAD_BEEF);

      // TOHOST and SCRATCH
      drive(1'b0, 32'h0, 1'b1, A_TOHOST, 32'd1);
      step();
      check("tohost1_v", {31'd0, tohost_valid}, 32'd1);
      check("tohost1_d", tohost_data, 32'd1);
      drive(1'b0, 32'h0, 1'b1, A_TOHOST, 32'd3);
      step();
      check("tohost3_v", {31'd0, tohost_valid}, 32'd1);
      check("tohost3_d", tohost_data, 32'd3);
      drive(1'b1, A_TOHOST, 1'b0, 32'h0, 32'h0);
      step();
      check("tohost_rd", data_rdata, 32'd3);
      drive(1'b1, A_SCRATCH, 1'b1, A_SCRATCH, 32'hA5A5_5A5A);
      step();
      check("scratch_wf", data_rdata, 32'hA5A5_5A5A);
      drive(1'b1, A_SCRATCH, 1'b0, 32'h0, 32'h0);
      step();
      check("scratch_rd", data_rdata, 32'hA5A5_5A5A);
      check("t4_err", {30'd0, err_misalign, err_range}, 32'd0);

      // Misalignment and range errors
      drive(1'b1, 32'h0000_0013, 1'b0, 32'h0, 32'h0);
      step();
      check("mis_data",   data_rdata, 32'hDEAD_BEEF);
      check("mis_flag",   {31'd0, err_misalign}, 32'd1);
      check("mis_norng",  {31'd0, err_range},    32'd0);
      drive(1'b0, 32'h0, 1'b1, 32'h2000_0000, 32'h5555_5555);
      step();
      check("rng_flag",   {31'd0, err_range}, 32'd1);
      drive(1'b1, 32'h2000_0000, 1'b0, 32'h0, 32'h0);
      step();
      check("rng_rv",     {31'd0, data_rvalid}, 32'd1);
      check("rng_rd0",    data_rdata, 32'h0);
      drive(1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0);
      step();
      check("rng_dropped", data_rdata, 32'h1111_1111);
      idle();
      step();
      step();
      check("flags_stick", {30'd0, err_misalign, err_range}, 32'd3);
      check("tohost_stick", {31'd0, tohost_valid}, 32'd1);

      // Asynchronous reset right after a read edge
      drive(1'b1, 32'h0000_0010, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      check("pre_rst_rv", {31'd0, data_rvalid}, 32'd1);
      rst_n = 1'b0;
      idle();
      #1;
      check("arst_rvalid", {31'd0, data_rvalid}, 32'd0);
      check("arst_rdata",  data_rdata, 32'h0);
      check("arst_flags",  {30'd0, err_misalign, err_range}, 32'd0);
      check("arst_tohv",   {31'd0, tohost_valid}, 32'd0);
      check("arst_tohd",   tohost_data, 32'h0);
      step();
      rst_n = 1'b1;
      step();                                 // cycle 0 after release
      check("no_stray_rv", {31'd0, data_rvalid}, 32'd0);
      drive(1'b1, A_MT_LO, 1'b0, 32'h0, 32'h0);
      step();                                 // cycle 1
      check("mtime_restart", data_rdata, 32'd1);
      drive(1'b1, A_SCRATCH, 1'b0, 32'h0, 32'h0);
      step();
      check("scratch_rst", data_rdata, 32'h0);
      idle();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Responder end of the core's data-memory interface: services the read-address/read-enable and write-address/write-enable/write-data requests issued by the MEM stage.
- Contains a word-organised data RAM and a small MMIO window (free-running 64-bit cycle counter, test-termination "tohost" register, scratch register).
- Sits outside the pipeline top, wired port-for-port to the core's data_* signals. Used as the simulation and FPGA data store.

Parameters:
- ADDR_W, 12: RAM word-index width; RAM holds 2^ADDR_W 32-bit words at byte addresses 0 .. 4*2^ADDR_W-1.
- MMIO_BASE, 32'h1000_0000: byte base of the 16-byte MMIO window.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_raddr  input  32  byte read address.
- data_re  input  1  read request, sampled at posedge.
- data_rdata  output  32  read data, registered.
- data_rvalid  output  1  high for exactly one cycle when data_rdata carries the response to the previous cycle's data_re.
- data_waddr  input  32  byte write address.
- data_we  input  1  write request, sampled at posedge.
- data_wdata  input  32  write data.
- tohost_valid  output  1  sticky, set by the first write to TOHOST.
- tohost_data  output  32  last value written to TOHOST.
- err_misalign  output  1  sticky, any access with addr[1:0] != 0.
- err_range  output  1  sticky, any access outside the RAM and MMIO regions.

Behaviour:
- Reset (rst_n low, asynchronous):
  - data_rdata=0, data_rvalid=0, tohost_valid=0, tohost_data=0, err_misalign=0, err_range=0.
  - Cycle counter=0, scratch=0.
  - RAM contents are not reset; the bench must not check them after reset.
  - A read in flight when reset asserts is discarded; no rvalid is produced after release.
- Address decode (the same decode applies to the read and write addresses independently):
  - RAM hit: addr[31:ADDR_W+2]==0; word index = addr[ADDR_W+1:2].
  - MMIO hit: addr[31:4]==MMIO_BASE[31:4]. Offsets:
    - 0x0: MTIME_LO (RO).
    - 0x4: MTIME_HI (RO).
    - 0x8: TOHOST (RW).
    - 0xC: SCRATCH (RW).
  - addr[1:0] are ignored for selection. If nonzero while the respective enable is high, err_misalign is set at that edge and the access proceeds aligned.
  - Neither hit while the enable is high: err_range is set. Reads return 0; writes are dropped.
- Write: when data_we=1 at posedge, the target updates at that edge. Writes to MTIME_LO/HI are ignored and raise no error.
  - TOHOST write: tohost_data<=data_wdata and tohost_valid<=1. tohost_valid stays 1 until reset; later writes update only tohost_data.
- Read (latency 1): when data_re=1 at posedge N, data_rdata holds the addressed value and data_rvalid=1 during cycle N+1.
  - When data_re=0, data_rvalid=0 and data_rdata holds its previous value.
  - Back-to-back reads give one response per cycle; there is no stall.
- Same-edge read and write to the same word (RAM or RW MMIO register): write-first. The read returns data_wdata.
- MTIME: the 64-bit counter increments by 1 every cycle after reset release and wraps 2^64-1 -> 0.
  - A read of MTIME_LO or MTIME_HI returns the counter value present before that edge's increment.
  - No lo/hi atomic latching is provided; software rereads HI.
- Simultaneous read/write to different addresses are independent. Both error flags can be set at the same edge.

Test Plan:
- Reset, write RAM 0x0000_0010=0xDEAD_BEEF, next cycle read 0x10 -> data_rvalid=1 one cycle later, data_rdata=0xDEAD_BEEF. No errors are set.
- Same-edge write 0x20=0x1234_5678 and read 0x20 -> rvalid next cycle with 0x1234_5678. Then three back-to-back reads of 0x10/0x20/0x10 -> rvalid held 3 cycles, data EF/78/EF words in order.
- Read MTIME_LO at the edge exactly 100 cycles after reset release -> data_rdata=100. Write 0xFFFF_FFFF to MTIME_LO -> ignored, subsequent read shows the counter continuing.
- Write TOHOST=1 -> tohost_valid=1, tohost_data=1 next cycle. Write TOHOST=3 -> tohost_data=3, tohost_valid still 1. Read TOHOST -> 3.
- Read 0x0000_0013 (misaligned) -> returns word 0x10 contents, err_misalign=1. Write 0x2000_0000 -> dropped, err_range=1; a read of 0x2000_0000 returns 0. Flags persist until reset.
- Assert rst_n low mid-cycle after a data_re edge -> data_rvalid, flags, and tohost drop to 0 immediately. After release, no stray rvalid and MTIME restarts from 0.
